// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline stage registers.
//   NOP_MIPS : canonical MIPS no-op (sll $0,$0,0). Stage registers drive it
//              in place of an instruction when they hold no entry.
//   if_id_t  : IF->ID payload layout. Later stage registers reuse the
//              struct-of-fields pattern.
//   if_id_pack : helper that builds an if_id_t from its two fields.
package pipe_pkg;

  localparam logic [31:0] NOP_MIPS = 32'h0000_0000;

  localparam int IF_ID_PC_W    = 32;
  localparam int IF_ID_INSTR_W = 32;

  typedef struct packed {
    logic [IF_ID_PC_W-1:0]    pc_plus4;
    logic [IF_ID_INSTR_W-1:0] instr;
  } if_id_t;

  function automatic if_id_t if_id_pack(input logic [IF_ID_PC_W-1:0]    pc_plus4,
                                        input logic [IF_ID_INSTR_W-1:0] instr);
    if_id_t r;
    r.pc_plus4 = pc_plus4;
    r.instr    = instr;
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register on a flat payload, with flush.
//
// Handshake: a beat moves on a port at a rising edge where valid & ready are
// both high. A producer holds valid and data steady until that edge, and
// valid never drops without a transfer except on flush. While out_valid is
// high and out_ready is low, out_data stays stable.
//
// Parameters
//   W    : payload width
//   SKID : 1 -> main + skid entry, in_ready comes straight from a flop
//          0 -> main entry only, in_ready = !m_valid | out_ready
// Ports
//   clk, rst_n         : rising-edge clock, async active-low reset
//   flush              : drop held entries and any same-cycle input beat
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload (main entry)
module pipe_skid_reg #(
  parameter int W    = 64,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_valid;
  logic [W-1:0] m_data;
  logic         accept;
  logic         m_free;

  assign accept    = in_valid & in_ready;
  // The main entry can take new data at this edge when it is empty or its
  // current entry leaves downstream at the same edge.
  assign m_free    = !m_valid | out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  if (SKID != 0) begin : g_skid
    logic         s_valid;
    logic [W-1:0] s_data;

    // The skid entry only fills while the main entry is held, so a low
    // in_ready here means at most one more beat was already in flight.
    assign in_ready = !s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        s_valid <= 1'b0;
        s_data  <= '0;
      end else if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (m_free) begin
        if (s_valid) begin
          // Older entry moves up first; in_ready was low so no beat arrives.
          m_valid <= 1'b1;
          m_data  <= s_data;
          s_valid <= 1'b0;
        end else begin
          m_valid <= accept;
          if (accept) m_data <= in_data;
        end
      end else if (accept) begin
        s_valid <= 1'b1;
        s_data  <= in_data;
      end
    end
  end else begin : g_single
    assign in_ready = m_free;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else if (flush) begin
        m_valid <= 1'b0;
      end else if (m_free) begin
        m_valid <= accept;
        if (accept) m_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline stage register.
// Carries {PC+4, instruction} from fetch to decode through a valid/ready
// register with optional skid entry. A flush (taken branch/jump resolved in
// ID) empties the stage. Whenever the stage holds nothing, out_instr shows
// NOP_INSTR so decode sees a bubble.
//
// Parameters
//   PC_W, INSTR_W : field widths, passed through bit-exact
//   NOP_INSTR     : encoding shown on out_instr while out_valid is low
//   SKID          : 1 -> registered in_ready with a two-entry buffer
// Ports
//   clk, rst_n                         : clock, async active-low reset
//   flush_i                            : drop held and incoming entries
//   in_valid, in_ready                 : fetch-side handshake
//   in_pc_plus4, in_instr              : fetched entry
//   out_valid, out_ready               : decode-side handshake
//   out_pc_plus4, out_instr            : held entry
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_MIPS),
  parameter int                 SKID      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc_plus4,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int W = PC_W + INSTR_W;

  logic [W-1:0]       in_flat;
  logic [W-1:0]       out_flat;
  logic [INSTR_W-1:0] held_instr;

  assign in_flat = {in_pc_plus4, in_instr};

  pipe_skid_reg #(
    .W    (W),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_flat)
  );

  assign {out_pc_plus4, held_instr} = out_flat;
  // Stale payload stays in the register after a consume or flush; the
  // override keeps decode from ever seeing it as an instruction.
  assign out_instr = out_valid ? held_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage: one SKID=1 instance and one SKID=0
// instance sharing clock and reset. Inputs change 1 time unit after a rising
// edge; outputs are checked at that point too, well away from the next edge.
module tb_if_id_pipe_stage;

  logic        clk;
  logic        rst_n;
  // SKID=1 instance
  logic        flush_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  // SKID=0 instance
  logic        flush_0;
  logic        in_valid_0;
  logic        in_ready_0;
  logic [31:0] in_pc_plus4_0;
  logic [31:0] in_instr_0;
  logic        out_valid_0;
  logic        out_ready_0;
  logic [31:0] out_pc_plus4_0;
  logic [31:0] out_instr_0;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_pipe_stage #(.SKID(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc_plus4  (in_pc_plus4),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr)
  );

  if_id_pipe_stage #(.SKID(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_0),
    .in_valid     (in_valid_0),
    .in_ready     (in_ready_0),
    .in_pc_plus4  (in_pc_plus4_0),
    .in_instr     (in_instr_0),
    .out_valid    (out_valid_0),
    .out_ready    (out_ready_0),
    .out_pc_plus4 (out_pc_plus4_0),
    .out_instr    (out_instr_0)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction word attached to each PC+4 in the stimulus.
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  // Expected outputs of the SKID=1 instance: empty -> valid 0 and NOP.
  task automatic exp_out(input string tag, input logic v, input logic [31:0] pc, input logic rdy);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    if (v) check({tag, ".pc"}, 64'(out_pc_plus4), 64'(pc));
    check({tag, ".instr"}, 64'(out_instr), v ? 64'(ins(pc)) : 64'h0);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
  endtask

  task automatic exp_out0(input string tag, input logic v, input logic [31:0] pc, input logic rdy);
    check({tag, ".valid"}, 64'(out_valid_0), 64'(v));
    if (v) check({tag, ".pc"}, 64'(out_pc_plus4_0), 64'(pc));
    check({tag, ".instr"}, 64'(out_instr_0), v ? 64'(ins(pc)) : 64'h0);
    check({tag, ".in_ready"}, 64'(in_ready_0), 64'(rdy));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid    = v;
    in_pc_plus4 = pc;
    in_instr    = ins(pc);
  endtask

  task automatic drive0(input logic v, input logic [31:0] pc);
    in_valid_0    = v;
    in_pc_plus4_0 = pc;
    in_instr_0    = ins(pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h04);
    flush_0     = 1'b0;
    out_ready_0 = 1'b1;
    drive0(1'b0, 32'h0);

    // 1. reset held with in_valid high: nothing enters
    step();
    step();
    exp_out("rst", 1'b0, 32'h0, 1'b1);
    check("rst.pc", 64'(out_pc_plus4), 64'h0);
    rst_n = 1'b1;
    step();                               // first edge after release accepts 0x04
    exp_out("rst_first", 1'b1, 32'h04, 1'b1);
    drive(1'b0, 32'h0);
    step();
    exp_out("rst_drain", 1'b0, 32'h0, 1'b1);

    // 2. streaming, out_ready=1
    drive(1'b1, 32'h04); step(); exp_out("strm0", 1'b1, 32'h04, 1'b1);
    drive(1'b1, 32'h08); step(); exp_out("strm1", 1'b1, 32'h08, 1'b1);
    drive(1'b1, 32'h0C); step(); exp_out("strm2", 1'b1, 32'h0C, 1'b1);
    drive(1'b0, 32'h0);  step(); exp_out("strm_end", 1'b0, 32'h0, 1'b1);

    // 3. stall with A in M, B lands in S, C waits upstream
    drive(1'b1, 32'h10); step(); exp_out("stl_a", 1'b1, 32'h10, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 32'h14); step(); exp_out("stl_b_in_s", 1'b1, 32'h10, 1'b0);
    drive(1'b1, 32'h18); step(); exp_out("stl_2", 1'b1, 32'h10, 1'b0);
    step();              exp_out("stl_3", 1'b1, 32'h10, 1'b0);
    out_ready = 1'b1;
    step();              exp_out("stl_b", 1'b1, 32'h14, 1'b1);
    step();              exp_out("stl_c", 1'b1, 32'h18, 1'b1);
    drive(1'b0, 32'h0);
    step();              exp_out("stl_end", 1'b0, 32'h0, 1'b1);

    // 4a. flush with M and S full and in_valid high
    out_ready = 1'b0;
    drive(1'b1, 32'h20); step();
    drive(1'b1, 32'h24); step(); exp_out("fl_full", 1'b1, 32'h20, 1'b0);
    drive(1'b1, 32'h28);
    flush_i = 1'b1;      step();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    exp_out("fl_full_after", 1'b0, 32'h0, 1'b1);
    // 4b. flush while in_ready=1: the same-cycle beat is dropped
    drive(1'b1, 32'h30); step(); exp_out("fl_m", 1'b1, 32'h30, 1'b1);
    drive(1'b1, 32'h34);
    flush_i = 1'b1;      step();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    exp_out("fl_drop", 1'b0, 32'h0, 1'b1);
    out_ready = 1'b1;
    step();              exp_out("fl_drop_later", 1'b0, 32'h0, 1'b1);

    // 5. async reset mid-cycle while stalled with M and S full
    out_ready = 1'b0;
    drive(1'b1, 32'h40); step();
    drive(1'b1, 32'h44); step(); exp_out("ar_full", 1'b1, 32'h40, 1'b0);
    drive(1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out("ar_clear", 1'b0, 32'h0, 1'b1);
    check("ar_clear.pc", 64'(out_pc_plus4), 64'h0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();              exp_out("ar_release", 1'b0, 32'h0, 1'b1);

    // 6. SKID=0 instance: streaming
    drive0(1'b1, 32'h04); step(); exp_out0("s0_strm0", 1'b1, 32'h04, 1'b1);
    drive0(1'b1, 32'h08); step(); exp_out0("s0_strm1", 1'b1, 32'h08, 1'b1);
    drive0(1'b1, 32'h0C); step(); exp_out0("s0_strm2", 1'b1, 32'h0C, 1'b1);
    drive0(1'b0, 32'h0);  step(); exp_out0("s0_strm_end", 1'b0, 32'h0, 1'b1);
    // SKID=0 stall: in_ready tracks out_ready combinationally while M is full
    drive0(1'b1, 32'h10); step(); exp_out0("s0_a", 1'b1, 32'h10, 1'b1);
    out_ready_0 = 1'b0;
    drive0(1'b1, 32'h14);
    #1; check("s0_comb_lo", 64'(in_ready_0), 64'h0);
    out_ready_0 = 1'b1;
    #1; check("s0_comb_hi", 64'(in_ready_0), 64'h1);
    out_ready_0 = 1'b0;
    #1; check("s0_comb_lo2", 64'(in_ready_0), 64'h0);
    step();               exp_out0("s0_stl1", 1'b1, 32'h10, 1'b0);
    step();               exp_out0("s0_stl2", 1'b1, 32'h10, 1'b0);
    step();               exp_out0("s0_stl3", 1'b1, 32'h10, 1'b0);
    out_ready_0 = 1'b1;
    step();               exp_out0("s0_b", 1'b1, 32'h14, 1'b1);
    drive0(1'b1, 32'h18); step(); exp_out0("s0_c", 1'b1, 32'h18, 1'b1);
    drive0(1'b0, 32'h0);  step(); exp_out0("s0_end", 1'b0, 32'h0, 1'b1);
    // SKID=0 flush drops the held entry and the same-cycle beat
    out_ready_0 = 1'b0;
    drive0(1'b1, 32'h50); step(); exp_out0("s0_fl_m", 1'b1, 32'h50, 1'b0);
    out_ready_0 = 1'b1;
    drive0(1'b1, 32'h54);
    flush_0 = 1'b1;       step();
    flush_0 = 1'b0;
    drive0(1'b0, 32'h0);
    exp_out0("s0_fl_after", 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
